// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master core between four requesters.
// Each grant issues one single-byte register read or write and returns the result to its owner.
module iic_bus_arbiter #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int TO_W        = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req_valid,
   input  logic [3:0]            req_rw,
   input  logic [27:0]           req_dev,
   input  logic [4*ADDR_W-1:0]   req_addr,
   input  logic [4*DATA_W-1:0]   req_wdata,
   output logic [3:0]            req_ack,
   output logic [3:0]            rsp_done,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_timeout,
   output logic                  iic_wr_en,
   output logic                  iic_re_en,
   output logic [6:0]            iic_dev,
   output logic [ADDR_W-1:0]     iic_addr,
   output logic [DATA_W-1:0]     iic_wdata,
   input  logic [DATA_W-1:0]     iic_rdata,
   input  logic                  iic_done,
   output logic                  busy,
   output logic [1:0]            grant_id
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam bit            TO_EN   = (TIMEOUT_CYC != 32'sd0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'sd1);

   state_t              state, state_nx;
   logic [1:0]          ptr, ptr_nx;
   logic                rw, rw_nx;
   logic                done_d;
   logic [TO_W-1:0]     cnt, cnt_nx;
   logic [3:0]          ack_nx, done_nx;
   logic                wr_nx, re_nx, to_nx, busy_nx;
   logic [DATA_W-1:0]   rsp_data_nx, wdata_nx;
   logic [6:0]          dev_nx;
   logic [ADDR_W-1:0]   addr_nx;
   logic [1:0]          grant_nx;
   logic [7:0]          rot;
   logic [1:0]          offset;
   logic [1:0]          sel;

   // Round-robin pick: rotate the request vector so ptr lands at bit 0, take the lowest set bit.
   always_comb begin
      rot = {req_valid, req_valid} >> ptr;
      casez (rot[3:0])
         4'b???1: offset = 2'd0;
         4'b??10: offset = 2'd1;
         4'b?100: offset = 2'd2;
         4'b1000: offset = 2'd3;
         default: offset = 2'd0;
      endcase
      sel = ptr + offset;
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      rw_nx       = rw;
      cnt_nx      = cnt;
      ack_nx      = 4'b0000;
      done_nx     = 4'b0000;
      wr_nx       = 1'b0;
      re_nx       = 1'b0;
      rsp_data_nx = rsp_data;
      to_nx       = rsp_timeout;
      dev_nx      = iic_dev;
      addr_nx     = iic_addr;
      wdata_nx    = iic_wdata;
      grant_nx    = grant_id;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               state_nx = ISSUE;
               grant_nx = sel;
               ptr_nx   = sel + 2'd1;
               rw_nx    = req_rw[sel];
               dev_nx   = req_dev[7*int'(sel) +: 7];
               addr_nx  = req_addr[ADDR_W*int'(sel) +: ADDR_W];
               wdata_nx = req_wdata[DATA_W*int'(sel) +: DATA_W];
               ack_nx   = 4'b0001 << sel;
               wr_nx    = ~req_rw[sel];
               re_nx    = req_rw[sel];
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            cnt_nx   = {TO_W{1'b0}};
            state_nx = WAIT;
         end
         WAIT: begin
            // Only a fresh rising edge counts, so a done level left over from before is ignored.
            if (iic_done && !done_d) begin
               rsp_data_nx = iic_rdata;
               to_nx       = 1'b0;
               done_nx     = 4'b0001 << grant_id;
               state_nx    = RESP;
            end else if (TO_EN && (cnt == TO_LAST)) begin
               rsp_data_nx = {DATA_W{1'b1}};
               to_nx       = 1'b1;
               done_nx     = 4'b0001 << grant_id;
               state_nx    = RESP;
            end else begin
               cnt_nx = cnt + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State, command and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 2'd0;
         rw          <= 1'b0;
         done_d      <= 1'b0;
         cnt         <= {TO_W{1'b0}};
         req_ack     <= 4'b0000;
         rsp_done    <= 4'b0000;
         rsp_data    <= {DATA_W{1'b0}};
         rsp_timeout <= 1'b0;
         iic_wr_en   <= 1'b0;
         iic_re_en   <= 1'b0;
         iic_dev     <= 7'd0;
         iic_addr    <= {ADDR_W{1'b0}};
         iic_wdata   <= {DATA_W{1'b0}};
         busy        <= 1'b0;
         grant_id    <= 2'd0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         rw          <= rw_nx;
         done_d      <= iic_done;
         cnt         <= cnt_nx;
         req_ack     <= ack_nx;
         rsp_done    <= done_nx;
         rsp_data    <= rsp_data_nx;
         rsp_timeout <= to_nx;
         iic_wr_en   <= wr_nx;
         iic_re_en   <= re_nx;
         iic_dev     <= dev_nx;
         iic_addr    <= addr_nx;
         iic_wdata   <= wdata_nx;
         busy        <= busy_nx;
         grant_id    <= grant_nx;
      end
   end

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Randomized self-checking bench for iic_bus_arbiter with a transaction-level reference model
// of the round-robin pointer and a behavioural I2C core driving iic_done / iic_rdata.
module tb_iic_bus_arbiter;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid, req_rw;
   logic [27:0] req_dev;
   logic [51:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_ack, rsp_done;
   logic [7:0]  rsp_data;
   logic        rsp_timeout, iic_wr_en, iic_re_en;
   logic [6:0]  iic_dev;
   logic [12:0] iic_addr;
   logic [7:0]  iic_wdata, iic_rdata;
   logic        iic_done, busy;
   logic [1:0]  grant_id;

   iic_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .TIMEOUT_CYC(TO), .TO_W(24)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .rsp_done(rsp_done), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .iic_wr_en(iic_wr_en), .iic_re_en(iic_re_en), .iic_dev(iic_dev),
      .iic_addr(iic_addr), .iic_wdata(iic_wdata), .iic_rdata(iic_rdata),
      .iic_done(iic_done), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   bit [6:0]  f_dev[4];
   bit [12:0] f_addr[4];
   bit [7:0]  f_wdata[4];
   bit        f_rw[4];
   logic [7:0] last_data;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_grant(input logic [3:0] mask, input int p);
      for (int k = 0; k < 4; k++) begin
         if (mask[(p + k) % 4]) return (p + k) % 4;
      end
      return 0;
   endfunction

   // force_rw: 0 = all writes, 1 = all reads, otherwise random
   task automatic set_fields(input int force_rw);
      for (int i = 0; i < 4; i++) begin
         f_dev[i]   = 7'($urandom);
         f_addr[i]  = 13'($urandom);
         f_wdata[i] = 8'($urandom);
         f_rw[i]    = (force_rw == 0) ? 1'b0 : (force_rw == 1) ? 1'b1 : 1'($urandom);
         req_dev[i*7 +: 7]    = f_dev[i];
         req_addr[i*13 +: 13] = f_addr[i];
         req_wdata[i*8 +: 8]  = f_wdata[i];
         req_rw[i]            = f_rw[i];
      end
   endtask

   function automatic logic [49:0] all_outputs();
      return {req_ack, rsp_done, rsp_data, rsp_timeout, iic_wr_en, iic_re_en,
              iic_dev, iic_addr, iic_wdata, busy, grant_id};
   endfunction

   // Called at a negedge of an IDLE cycle; returns at the negedge of the ISSUE cycle.
   task automatic start_grant(input logic [3:0] mask, output int g);
      req_valid = mask;
      g = model_grant(mask, model_ptr);
      model_ptr = (g + 1) % 4;
      @(negedge clk);
      check_eq("req_ack", req_ack, 4'b0001 << g);
      check_eq("iic_en", {iic_wr_en, iic_re_en}, f_rw[g] ? 2'b01 : 2'b10);
      check_eq("issue_busy_grant", {busy, grant_id}, {1'b1, 2'(g)});
      check_eq("iic_cmd", {iic_dev, iic_addr, iic_wdata}, {f_dev[g], f_addr[g], f_wdata[g]});
   endtask

   // mode 0: done rises at cycle d1; mode 1: stale high through ISSUE, low at d1, rises at d2;
   // mode 2: no done, timeout expected. Returns at the negedge of the IDLE cycle after RESP.
   task automatic finish_txn(input int g, input int mode, input int d1, input int d2,
                             input logic [7:0] rd, input bit hold, input logic [3:0] mask);
      int x;
      int done_at;
      done_at = (mode == 1) ? d2 : d1;
      x = (mode == 2) ? TO + 1 : done_at + 1;
      iic_done = (mode == 1);
      req_valid = hold ? mask : 4'($urandom);
      for (int c = 1; c <= x; c++) begin
         @(negedge clk);
         if (c < x) begin
            check_eq("wait_quiet", {req_ack, rsp_done, iic_wr_en, iic_re_en, busy}, 11'b1);
         end else begin
            check_eq("rsp_done", rsp_done, 4'b0001 << g);
            check_eq("rsp_timeout", rsp_timeout, (mode == 2));
            if (mode == 2 || f_rw[g]) begin
               check_eq("rsp_data", rsp_data, (mode == 2) ? 8'hFF : rd);
            end
            check_eq("cmd_held", {iic_dev, iic_addr, iic_wdata}, {f_dev[g], f_addr[g], f_wdata[g]});
         end
         if (mode != 2 && c == done_at) begin
            iic_done = 1'b1;
            iic_rdata = rd;
         end else begin
            iic_rdata = 8'($urandom);
            if (mode == 1 && c == d1) iic_done = 1'b0;
         end
         if (c == x) iic_done = (mode == 2);
         if (!hold) req_valid = 4'($urandom);
      end
      last_data = rsp_data;
      @(negedge clk);
      iic_done = 1'b0;
      for (int k = 0; k < 300 && busy; k++) @(negedge clk);
      check_eq("idle_after_resp", {busy, rsp_done, req_ack}, 9'b0);
      check_eq("rsp_held", {rsp_data, rsp_timeout}, {last_data, 1'(mode == 2)});
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
   endtask

   initial begin
      int g;
      int mode;
      int d1;
      logic [3:0] m;
      rst = 1'b1;
      req_valid = 4'b0;
      iic_done = 1'b0;
      iic_rdata = 8'h00;
      set_fields(2);
      #1;
      check_eq("reset_outputs", all_outputs(), 50'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single read from requester 1
      set_fields(2);
      f_rw[1] = 1'b1; f_dev[1] = 7'h68; f_addr[1] = 13'h002;
      req_rw[1] = 1'b1; req_dev[13:7] = 7'h68; req_addr[25:13] = 13'h002;
      start_grant(4'b0010, g);
      finish_txn(g, 0, 40, 0, 8'h59, 1'b0, 4'b0010);

      // all four write at once, two rounds from a fresh reset
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         set_fields(0);
         start_grant(4'b1111, g);
         finish_txn(g, 0, $urandom_range(1, 10), 0, 8'($urandom), 1'b1, 4'b1111);
      end

      // fairness between requesters 0 and 2
      for (int i = 0; i < 4; i++) begin
         set_fields(2);
         start_grant(4'b0101, g);
         finish_txn(g, 0, $urandom_range(1, 6), 0, 8'($urandom), 1'b1, 4'b0101);
      end

      // timeout followed by a normal completion
      set_fields(1);
      start_grant(4'b0100, g);
      finish_txn(g, 2, 0, 0, 8'h00, 1'b0, 4'b0100);
      set_fields(1);
      start_grant(4'b0100, g);
      finish_txn(g, 0, 7, 0, 8'hA5, 1'b0, 4'b0100);

      // stale done held across ISSUE
      set_fields(1);
      start_grant(4'b1000, g);
      finish_txn(g, 1, 3, 8, 8'h3C, 1'b0, 4'b1000);

      // reset while waiting on the core; pointer must restart at 0
      set_fields(2);
      start_grant(4'b0001, g);
      finish_txn(g, 0, 2, 0, 8'h11, 1'b0, 4'b0001);
      set_fields(1);
      start_grant(4'b0100, g);
      req_valid = 4'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("async_reset_outputs", all_outputs(), 50'd0);
      @(negedge clk);
      check_eq("reset_no_rsp", {rsp_done, busy}, 5'd0);
      rst = 1'b0;
      model_ptr = 0;
      set_fields(2);
      start_grant(4'b1001, g);
      finish_txn(g, 0, 4, 0, 8'h77, 1'b0, 4'b1001);
      set_fields(2);
      start_grant(4'b1000, g);
      finish_txn(g, 0, 4, 0, 8'h88, 1'b0, 4'b1000);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         set_fields(2);
         m = 4'($urandom_range(1, 15));
         mode = ($urandom_range(0, 9) < 7) ? 0 : ($urandom_range(0, 2) == 0 ? 2 : 1);
         d1 = $urandom_range(1, 25);
         start_grant(m, g);
         finish_txn(g, mode, d1, d1 + $urandom_range(1, 15), 8'($urandom), 1'($urandom), m);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iic_bus_arbiter.md
# iic_bus_arbiter

Round-robin arbiter and sequencer that shares the single I2C master core (IIC_COR) between four independent requesters, such as the RTC poller, an EEPROM config writer and a sensor reader. It accepts one single-byte register read or write per grant, drives the core's command inputs with a one-cycle enable pulse, and waits for the core's `done`. It then returns read data, or a timeout flag, to the granted requester only. The block sits between the requester FSMs and the IIC_COR instance; the core's `num_*` inputs stay tied to 1 outside this block.

## Interface

Parameters:
- `ADDR_W`, default 13: register address width; matches the core's `addr_se_reg`.
- `DATA_W`, default 8: data byte width.
- `TIMEOUT_CYC`, default 1000000: WAIT-state cycle limit. 0 disables the timeout.
- `TO_W`, default 24: timeout counter width. Must satisfy TIMEOUT_CYC < 2^TO_W.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, in, 1: system clock.
  - `rst`, in, 1: asynchronous, active-high reset.
- Requester side:
  - `req_valid`, in, 4: request pending, one bit per requester.
  - `req_rw`, in, 4: 1 = read, 0 = write, per requester.
  - `req_dev`, in, 4×7: 7-bit device address per requester; slice i is bits [7i+6:7i].
  - `req_addr`, in, 4×ADDR_W: register address per requester.
  - `req_wdata`, in, 4×DATA_W: write byte per requester.
  - `req_ack`, out, 4: one-cycle pulse when the request is accepted.
  - `rsp_done`, out, 4: one-cycle completion pulse to the granted requester.
  - `rsp_data`, out, DATA_W: read byte; valid while `rsp_done` is high and held until the next response.
  - `rsp_timeout`, out, 1: high with `rsp_done` when the transfer timed out; held until the next response.
- Core side:
  - `iic_wr_en`, out, 1: write command pulse to the core.
  - `iic_re_en`, out, 1: read command pulse to the core.
  - `iic_dev`, out, 7: device address to the core.
  - `iic_addr`, out, ADDR_W: register address to the core.
  - `iic_wdata`, out, DATA_W: write byte to the core.
  - `iic_rdata`, in, DATA_W: read byte from the core.
  - `iic_done`, in, 1: core completion; level or pulse, only the rising edge is used.
- Status:
  - `busy`, out, 1: high in every state except IDLE.
  - `grant_id`, out, 2: index of the current or last granted requester.

## Operation

**State machine:** IDLE → ISSUE → WAIT → RESP → IDLE.

**IDLE**
- If any `req_valid` bit is high, select the first set bit scanning from `ptr` upward, modulo 4.
- Latch rw, dev, addr and wdata of the selected requester into command registers, and latch `grant_id`.
- Set `ptr` = grant+1 mod 4. Go to ISSUE.

**ISSUE** (exactly 1 cycle)
- `req_ack[grant]` = 1.
- `iic_wr_en` = !rw and `iic_re_en` = rw. Exactly one of the two is high.
- Clear the timeout counter. Go to WAIT.

**WAIT**
- `iic_done` is registered into `done_d`; a rising edge is `iic_done & !done_d`.
- On a rising edge: capture `iic_rdata` into `rsp_data`, clear `rsp_timeout`, go to RESP.
- Otherwise, if TIMEOUT_CYC ≠ 0 and the counter equals TIMEOUT_CYC-1: set `rsp_data` = all ones and `rsp_timeout` = 1, go to RESP.
- Otherwise increment the counter.

**RESP** (1 cycle)
- `rsp_done[grant]` = 1. Go to IDLE.

**Core command outputs**
- `iic_dev`, `iic_addr` and `iic_wdata` come from the command registers and are held stable from ISSUE until the next grant.
- On a write, `rsp_data` still captures `iic_rdata`; its value is don't-care for writes.

**Boundary conditions**
- Requester handshake: the requester holds fields stable while `req_valid` is high and until `req_ack`. Fields may change from the cycle after `req_ack`.
- If `req_valid` drops before a grant, the request is withdrawn with no effect.
- If `req_valid` is still high in the cycle after `rsp_done`, that is a new request.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority.
- Requests arriving while `busy` wait; nothing is queued inside the block.
- `iic_done` already high when WAIT is entered is not an edge. Completion requires a fresh rising edge, so a stale done is ignored.
- A timeout does not reset the core. A late `iic_done` edge that arrives after RESP is ignored, because edges are only acted on in WAIT.
- `rst` asserted in any state:
  - All outputs go to 0 immediately, including `iic_wr_en` and `iic_re_en`.
  - State returns to IDLE, `ptr` = 0, `done_d` = 0, counter = 0.
  - An in-flight request gets no `rsp_done`.

## Timing

- Reset values: `req_ack`, `rsp_done`, `iic_wr_en`, `iic_re_en` = 0; `rsp_data`, `rsp_timeout`, `iic_dev`, `iic_addr`, `iic_wdata`, `grant_id` = 0; `busy` = 0.
- All outputs are registered.
- Grant: `req_valid` is sampled high at edge E with the block in IDLE. `req_ack` and the core enable are high in the cycle after E; `busy` is high from the same cycle.
- Response: the `iic_done` rising edge is sampled at edge D. `rsp_done` is high in the cycle after D.
- Back-to-back: the next grant is sampled at the edge ending the IDLE cycle after RESP. Minimum spacing is 4 cycles plus core time.
- Timeout: `rsp_done` is high at TIMEOUT_CYC+1 cycles after ISSUE.

## Test plan

1. **Single read:** req1 reads dev 7'h68, addr 13'h002; the core raises done 40 cycles after `iic_re_en` with `iic_rdata` = 8'h59. Expect `req_ack` = 4'b0010 for 1 cycle, a single `iic_re_en` pulse with `iic_addr` = 2, then `rsp_done` = 4'b0010 with `rsp_data` = 8'h59 one cycle after the done edge.
2. **All four at once:** all requesters write simultaneously after reset. Expect grants in order 0, 1, 2, 3, each with the correct `iic_wdata`. A second round starts at 0.
3. **Fairness:** req0 and req2 are held valid continuously. Expect the grant sequence 0, 2, 0, 2; req1 and req3 never receive an ack.
4. **Timeout:** TIMEOUT_CYC = 100 and the core never raises done. Expect `rsp_done`, `rsp_timeout` = 1 and `rsp_data` = 8'hFF 101 cycles after ISSUE. The following request then completes normally with `rsp_timeout` = 0.
5. **Stale done:** `iic_done` is held high across ISSUE, then falls and rises again. Expect completion only on the second rising edge.
6. **Reset in WAIT:** assert `rst` mid-transfer. Expect all outputs 0 asynchronously and no `rsp_done`. After release with req3 valid, req3 is granted; `ptr` started from 0.
